register_file_mp: RTL

Parametrised next-generation register file for the single-cycle and upcoming pipelined RISC-V cores. It has two asynchronous read ports and two synchronous write ports with fixed priority, plus optional same-cycle write-to-read bypass. A per-register busy scoreboard lets the issue stage detect RAW hazards against in-flight writebacks. It sits between decode (read/issue) and writeback.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_scoreboard.sv | 53 +++++
 rtl/register_file_mp.sv | 117 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam logic [31:0] ZERO_REG = '0;

    // Returns 2'b10 when port 1 lands on addr, 2'b01 when only port 0 does, 2'b00 otherwise.
    function automatic logic [1:0] write_sel(
        input logic        we0,
        input logic        we1,
        input logic [31:0] wa0,
        input logic [31:0] wa1,
        input logic [31:0] addr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (addr != ZERO_REG) begin
            if (we1 && (wa1 == addr)) begin
                sel = 2'b10;
            end else if (we0 && (wa0 == addr)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, final writeback clears, and issue beats clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic          we0,
    input  logic          wb_clr0,
    input  logic [AW-1:0] wa0,
    input  logic          we1,
    input  logic          wb_clr1,
    input  logic [AW-1:0] wa1,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // The issue is applied last so a new producer overrides a same-cycle clear.
    always_comb begin
        busy_d = busy_q;
        if (we0 && wb_clr0 && (wa0 != '0)) begin
            busy_d[wa0] = 1'b0;
        end
        if (we1 && wb_clr1 && (wa1 != '0)) begin
            busy_d[wa1] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];

endmodule

// File: rtl/register_file_mp.sv
// Two-read / two-write register file with x0 hardwired, optional write-to-read bypass and busy scoreboard.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   wa0,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd0,
    input  logic [XLEN-1:0] wd1,
    input  logic            wb_clr0,
    input  logic            wb_clr1
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            sb_busy1;
    logic            sb_busy2;
    logic            clr_hit1;
    logic            clr_hit2;

    always_comb begin
        logic [1:0] sel;
        sel = 2'b00;
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            sel = write_sel(we0, we1, 32'(wa0), 32'(wa1), 32'(i));
            if (sel[1]) begin
                regs_d[i] = wd1;
            end else if (sel[0]) begin
                regs_d[i] = wd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reset gates the bypass path too, so reads are zero while rst is low.
    always_comb begin
        logic [1:0] sel1;
        logic [1:0] sel2;
        sel1 = write_sel(we0, we1, 32'(wa0), 32'(wa1), 32'(rs1));
        sel2 = write_sel(we0, we1, 32'(wa0), 32'(wa1), 32'(rs2));
        rd_data1 = regs_q[rs1];
        rd_data2 = regs_q[rs2];
        if (BYPASS != 0) begin
            if (sel1[1]) begin
                rd_data1 = wd1;
            end else if (sel1[0]) begin
                rd_data1 = wd0;
            end
            if (sel2[1]) begin
                rd_data2 = wd1;
            end else if (sel2[0]) begin
                rd_data2 = wd0;
            end
        end
        if (!rst || (rs1 == '0)) begin
            rd_data1 = '0;
        end
        if (!rst || (rs2 == '0)) begin
            rd_data2 = '0;
        end
    end

    regfile_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .we0        (we0),
        .wb_clr0    (wb_clr0),
        .wa0        (wa0),
        .we1        (we1),
        .wb_clr1    (wb_clr1),
        .wa1        (wa1),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_busy   (sb_busy1),
        .rs2_busy   (sb_busy2)
    );

    // A forwarded final writeback makes the operand available in the same cycle.
    assign clr_hit1 = (we0 && wb_clr0 && (wa0 == rs1)) || (we1 && wb_clr1 && (wa1 == rs1));
    assign clr_hit2 = (we0 && wb_clr0 && (wa0 == rs2)) || (we1 && wb_clr1 && (wa1 == rs2));

    assign rs1_busy = sb_busy1 && !((BYPASS != 0) && clr_hit1);
    assign rs2_busy = sb_busy2 && !((BYPASS != 0) && clr_hit2);

endmodule
